// File: rtl/mips32_pkg.sv
// Shared package: FSM state encoding for the memory arbiter.
package mips32_pkg;

  // One access in flight: latch in IDLE, drive RAM in ACCESS, acknowledge in RESP.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Last-served pointer after reset: requester 1, so requester 0 wins the first tie.
  localparam logic LAST_AFTER_RESET = 1'b1;

endpackage

// File: rtl/ram.sv
// Single-port RAM with a shared bidirectional data bus and combinational read.
module ram #(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                  clock,
  input  logic                  read,
  input  logic                  write,
  input  logic [addr_width-1:0] address,
  inout  wire  [data_width-1:0] data
);

  // NOTE: the storage array has no reset; clearing every word would cost a
  // reset fan-out to the whole array and contents are defined by writes.
  logic [data_width-1:0] mem [2**addr_width];

  // Commit a write at the clock edge.
  always_ff @(posedge clock) begin
    if (write) begin
      mem[address] <= data;
    end
  end

  // Drive the bus only while a read is requested; otherwise release it.
  assign data = (read && !write) ? mem[address] : {data_width{1'bz}};

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant
);

  // grant = 0 selects requester 0, grant = 1 selects requester 1.
  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: round-robin grant, one access in flight,
// fixed three-cycle IDLE -> ACCESS -> RESP sequence.
module mem_arbiter
  import mips32_pkg::*;
#(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [addr_width-1:0] addr0,
  input  logic [addr_width-1:0] addr1,
  input  logic [data_width-1:0] wdata0,
  input  logic [data_width-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [data_width-1:0] rdata0,
  output logic [data_width-1:0] rdata1,
  output logic                  ram_read,
  output logic                  ram_write,
  output logic [addr_width-1:0] ram_address,
  inout  wire  [data_width-1:0] ram_data
);

  arb_state_t            state_q, state_d;
  logic                  arb_grant;
  logic                  grant_q;
  logic                  we_q;
  logic [addr_width-1:0] addr_q;
  logic [data_width-1:0] wdata_q;
  logic                  last_q;
  logic [data_width-1:0] rdata0_q, rdata1_q;
  logic                  drive_en;

  rr_arb2 u_rr_arb2 (
    .req0  (req0),
    .req1  (req1),
    .last  (last_q),
    .grant (arb_grant)
  );

  // State register; reset returns to IDLE and aborts any access in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: latch the winner in IDLE, capture read data at the end of
  // ACCESS, and record the served requester in RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      last_q   <= LAST_AFTER_RESET;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (state_q == IDLE && (req0 || req1)) begin
        grant_q <= arb_grant;
        we_q    <= arb_grant ? we1    : we0;
        addr_q  <= arb_grant ? addr1  : addr0;
        wdata_q <= arb_grant ? wdata1 : wdata0;
      end
      if (state_q == ACCESS && !we_q) begin
        if (grant_q) begin
          rdata1_q <= ram_data;
        end else begin
          rdata0_q <= ram_data;
        end
      end
      if (state_q == RESP) begin
        last_q <= grant_q;
      end
    end
  end

  // Next state and decoded outputs; RAM controls are only active in ACCESS.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    ram_read    = 1'b0;
    ram_write   = 1'b0;
    ram_address = '0;
    drive_en    = 1'b0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        ram_read    = ~we_q;
        ram_write   = we_q;
        ram_address = addr_q;
        drive_en    = we_q;
        state_d     = RESP;
      end
      RESP: begin
        ack0    = ~grant_q;
        ack1    = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_data = drive_en ? wdata_q : {data_width{1'bz}};
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter driving the ram model.
module tb_mem_arbiter;
  import mips32_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  wire        ack0, ack1;
  wire  [7:0] rdata0, rdata1;
  wire        ram_read, ram_write;
  wire  [7:0] ram_address;
  wire  [7:0] ram_data;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  always #5 clock = ~clock;

  mem_arbiter #(.addr_width(8), .data_width(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .ack0        (ack0),
    .ack1        (ack1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .ram_read    (ram_read),
    .ram_write   (ram_write),
    .ram_address (ram_address),
    .ram_data    (ram_data)
  );

  ram #(.addr_width(8), .data_width(8)) u_ram (
    .clock   (clock),
    .read    (ram_read),
    .write   (ram_write),
    .address (ram_address),
    .data    (ram_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One complete access by a single requester with its fixed timing.
  task automatic single(input bit port, input bit we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] rexp, input string tag);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end
    tick;
    check({tag, ":acc_addr"}, ram_address, addr);
    check({tag, ":acc_read"}, ram_read, !we);
    check({tag, ":acc_write"}, ram_write, we);
    if (we) check({tag, ":acc_bus"}, ram_data, wdata);
    check({tag, ":no_early_ack"}, {ack1, ack0}, 2'b00);
    tick;
    check({tag, ":ack"}, {ack1, ack0}, port ? 2'b10 : 2'b01);
    if (!we) check({tag, ":rdata"}, port ? rdata1 : rdata0, rexp);
    if (port) req1 = 1'b0; else req0 = 1'b0;
    tick;
    check({tag, ":ack_pulse"}, {ack1, ack0}, 2'b00);
  endtask

  // Bus invariants sampled away from the active edge.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      check("mon:rd_wr_excl", ram_read && ram_write, 1'b0);
      check("mon:ack_excl", ack0 && ack1, 1'b0);
      if (!ram_read && !ram_write) check("mon:idle_addr", ram_address, 8'h00);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    tick;
    tick;
    check("rst:ack0", ack0, 1'b0);
    check("rst:ack1", ack1, 1'b0);
    check("rst:rdata0", rdata0, 8'h00);
    check("rst:rdata1", rdata1, 8'h00);
    check("rst:ram_read", ram_read, 1'b0);
    check("rst:ram_write", ram_write, 1'b0);
    check("rst:ram_address", ram_address, 8'h00);
    check("rst:state", dut.state_q, IDLE);
    reset = 1'b0;
    mon_en = 1'b1;

    // First tie after reset: requester 0 wins, requester 1 acked 3 cycles later.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    tick;
    check("tie1:first_addr", ram_address, 8'h01);
    check("tie1:first_read", ram_read, 1'b1);
    tick;
    check("tie1:first_ack", {ack1, ack0}, 2'b01);
    req0 = 1'b0;
    tick;
    check("tie1:gap_ack", {ack1, ack0}, 2'b00);
    tick;
    check("tie1:second_addr", ram_address, 8'h02);
    check("tie1:second_no_ack", {ack1, ack0}, 2'b00);
    tick;
    check("tie1:second_ack", {ack1, ack0}, 2'b10);
    req1 = 1'b0;
    tick;

    // Write then read back through requester 0.
    single(1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, "wr0_10");
    single(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, "rd0_10");

    // Isolation between requesters.
    single(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, "rd1_10");
    single(1'b1, 1'b1, 8'h20, 8'h3C, 8'h00, "wr1_20");
    check("iso:rdata1_after_write", rdata1, 8'hA5);
    single(1'b0, 1'b0, 8'h20, 8'h00, 8'h3C, "rd0_20");
    check("iso:rdata1_unchanged", rdata1, 8'hA5);

    // Preload tie addresses; requester 0 is served last afterwards.
    single(1'b0, 1'b1, 8'h01, 8'h5A, 8'h00, "wr0_01");
    single(1'b0, 1'b1, 8'h02, 8'hC3, 8'h00, "wr0_02");

    // Tie with requester 0 served last: requester 1 wins first.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    tick;
    check("tie2:first_addr", ram_address, 8'h02);
    tick;
    check("tie2:first_ack", {ack1, ack0}, 2'b10);
    check("tie2:rdata1", rdata1, 8'hC3);
    req1 = 1'b0;
    tick;
    tick;
    check("tie2:second_addr", ram_address, 8'h01);
    tick;
    check("tie2:second_ack", {ack1, ack0}, 2'b01);
    check("tie2:rdata0", rdata0, 8'h5A);
    req0 = 1'b0;
    tick;

    // Back-to-back: req1 held past its ack becomes a second request.
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
    tick;
    tick;
    check("b2b:ack_first", {ack1, ack0}, 2'b10);
    check("b2b:rdata1_first", rdata1, 8'hA5);
    addr1 = 8'h20;
    tick;
    check("b2b:gap1", {ack1, ack0}, 2'b00);
    tick;
    check("b2b:second_addr", ram_address, 8'h20);
    check("b2b:gap2", {ack1, ack0}, 2'b00);
    tick;
    check("b2b:ack_second", {ack1, ack0}, 2'b10);
    check("b2b:rdata1_second", rdata1, 8'h3C);
    req1 = 1'b0;
    tick;
    tick;
    check("b2b:settled_ack", {ack1, ack0}, 2'b00);
    check("b2b:settled_read", ram_read, 1'b0);

    // Reset during ACCESS of a req0 read aborts it; held req0 then completes.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    tick;
    check("rstmid:in_access", ram_read, 1'b1);
    reset = 1'b1;
    tick;
    check("rstmid:no_ack0", ack0, 1'b0);
    check("rstmid:state", dut.state_q, IDLE);
    check("rstmid:rdata0", rdata0, 8'h00);
    check("rstmid:ram_read", ram_read, 1'b0);
    reset = 1'b0;
    tick;
    check("rstmid:retry_addr", ram_address, 8'h10);
    check("rstmid:retry_no_ack", ack0, 1'b0);
    tick;
    check("rstmid:retry_ack", {ack1, ack0}, 2'b01);
    check("rstmid:retry_rdata0", rdata0, 8'hA5);
    req0 = 1'b0;
    tick;
    tick;

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
